// File: rtl/sram_ctrl_ws_if.sv
// Bus and chip-side signal bundle for sram_ctrl_ws.
// master: CPU/bus side plus pad wrapper (drives requests and I_chip_din).
// slave : the controller (drives completion, status and chip strobes).
interface sram_ctrl_ws_if #(
  parameter int unsigned ADDRBITS = 18,
  parameter int unsigned DATABITS = 16
);
  localparam int unsigned BYTES = DATABITS / 8;

  // Request side
  logic                I_stb;
  logic                I_write;
  logic [BYTES-1:0]    I_sel;
  logic [ADDRBITS-1:0] I_addr;
  logic [DATABITS-1:0] I_data;
  logic [DATABITS-1:0] O_data;
  logic                O_ack;
  logic                O_busy;

  // Chip side
  logic [ADDRBITS-1:0] O_chip_addr;
  logic [DATABITS-1:0] O_chip_dout;
  logic                O_chip_doe;
  logic [DATABITS-1:0] I_chip_din;
  logic                O_chip_ce_n;
  logic                O_chip_oe_n;
  logic                O_chip_we_n;
  logic [BYTES-1:0]    O_chip_be_n;

  modport master (
    output I_stb, I_write, I_sel, I_addr, I_data, I_chip_din,
    input  O_data, O_ack, O_busy, O_chip_addr, O_chip_dout, O_chip_doe,
           O_chip_ce_n, O_chip_oe_n, O_chip_we_n, O_chip_be_n
  );

  modport slave (
    input  I_stb, I_write, I_sel, I_addr, I_data, I_chip_din,
    output O_data, O_ack, O_busy, O_chip_addr, O_chip_dout, O_chip_doe,
           O_chip_ce_n, O_chip_oe_n, O_chip_we_n, O_chip_be_n
  );
endinterface

// File: rtl/sram_ctrl_ws.sv
// Async-SRAM controller with N byte lanes, programmable read/write wait
// states and post-write bus turnaround.
// Ports:
//   I_clk      - system clock, rising edge
//   I_reset_n  - asynchronous active-low reset
//   bus        - sram_ctrl_ws_if.slave: stb/ack request side and registered
//                chip-side strobes, address, write data and data-pad enable
module sram_ctrl_ws #(
  parameter int unsigned ADDRBITS   = 18,
  parameter int unsigned DATABITS   = 16,
  parameter int unsigned READ_WAIT  = 1,
  parameter int unsigned WRITE_WAIT = 1,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic          I_clk,
  input  logic          I_reset_n,
  sram_ctrl_ws_if.slave bus
);

  localparam int unsigned BYTES = DATABITS / 8;
  localparam int unsigned CNT_W = 4;

  localparam logic [CNT_W-1:0] RD_INIT   = CNT_W'(READ_WAIT);
  localparam logic [CNT_W-1:0] WR_INIT   = CNT_W'(WRITE_WAIT);
  // TURN is entered already counting its first cycle, hence the minus one.
  localparam logic [CNT_W-1:0] TURN_INIT = (TURNAROUND == 0) ? '0 : CNT_W'(TURNAROUND - 1);

  // Reject parameter values the 4-bit counter or byte lanes cannot represent.
  if (READ_WAIT > 15 || WRITE_WAIT > 15 || TURNAROUND > 15) begin : g_bad_wait
    $error("sram_ctrl_ws: READ_WAIT/WRITE_WAIT/TURNAROUND must be 0..15");
  end
  if (DATABITS == 0 || (DATABITS % 8) != 0) begin : g_bad_width
    $error("sram_ctrl_ws: DATABITS must be a non-zero multiple of 8");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    TURN     = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDRBITS-1:0] addr_q, addr_d;
  logic [DATABITS-1:0] dout_q, dout_d;
  logic [DATABITS-1:0] data_q, data_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                doe_q, doe_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic [BYTES-1:0]    be_n_q, be_n_d;

  // Next-state and next-output decode; every pad value is computed here and
  // registered, so request inputs never reach the pads combinationally.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    data_d  = data_q;
    ack_d   = 1'b0;
    doe_d   = doe_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    be_n_d  = be_n_q;

    unique case (state_q)
      IDLE: begin
        if (bus.I_stb) begin
          addr_d = bus.I_addr;
          be_n_d = ~bus.I_sel;
          ce_n_d = 1'b0;
          if (bus.I_write) begin
            dout_d  = bus.I_data;
            doe_d   = 1'b1;
            state_d = WR_SETUP;
          end else begin
            oe_n_d  = 1'b0;
            cnt_d   = RD_INIT;
            state_d = RD;
          end
        end
      end
      RD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          data_d  = bus.I_chip_din;
          ack_d   = 1'b1;
          oe_n_d  = 1'b1;
          ce_n_d  = 1'b1;
          be_n_d  = '1;
          state_d = IDLE;
        end
      end
      WR_SETUP: begin
        we_n_d  = 1'b0;
        cnt_d   = WR_INIT;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          we_n_d  = 1'b1;
          state_d = WR_HOLD;
        end
      end
      WR_HOLD: begin
        ack_d  = 1'b1;
        doe_d  = 1'b0;
        ce_n_d = 1'b1;
        be_n_d = '1;
        if (TURNAROUND != 0) begin
          cnt_d   = TURN_INIT;
          state_d = TURN;
        end else begin
          state_d = IDLE;
        end
      end
      TURN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        doe_d   = 1'b0;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        be_n_d  = '1;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops every strobe immediately.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      doe_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      doe_q   <= doe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
    end
  end

  assign bus.O_data      = data_q;
  assign bus.O_ack       = ack_q;
  assign bus.O_busy      = busy_q;
  assign bus.O_chip_addr = addr_q;
  assign bus.O_chip_dout = dout_q;
  assign bus.O_chip_doe  = doe_q;
  assign bus.O_chip_ce_n = ce_n_q;
  assign bus.O_chip_oe_n = oe_n_q;
  assign bus.O_chip_we_n = we_n_q;
  assign bus.O_chip_be_n = be_n_q;

  // The controller must never drive the data pads while the SRAM drives them.
  a_no_bus_fight: assert property (@(posedge I_clk) disable iff (!I_reset_n)
    !(doe_q && !oe_n_q));

endmodule

// File: tb/tb_sram_ctrl_ws.sv
// Testbench for sram_ctrl_ws: behavioural async-SRAM model, reference memory
// and a scoreboard of expected completions (data and ack cycle).
module tb_sram_ctrl_ws;

  localparam int unsigned RW = 1;
  localparam int unsigned WW = 1;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  sram_ctrl_ws_if #(.ADDRBITS(18), .DATABITS(16)) bus ();
  sram_ctrl_ws_if #(.ADDRBITS(18), .DATABITS(16)) bus2 ();

  sram_ctrl_ws #(.READ_WAIT(RW), .WRITE_WAIT(WW), .TURNAROUND(1)) dut (
    .I_clk(clk), .I_reset_n(rst_n), .bus(bus)
  );
  sram_ctrl_ws #(.READ_WAIT(1), .WRITE_WAIT(1), .TURNAROUND(2)) dut2 (
    .I_clk(clk), .I_reset_n(rst_n), .bus(bus2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // SRAM chip model and independent reference memory
  logic [15:0] mem     [logic [17:0]];
  logic [15:0] ref_mem [logic [17:0]];
  logic [15:0] wtmp;

  function automatic logic [15:0] dflt(input logic [17:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction
  function automatic logic [15:0] sram_rd(input logic [17:0] a);
    if (mem.exists(a)) return mem[a];
    return dflt(a);
  endfunction
  function automatic logic [15:0] ref_rd(input logic [17:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  always @(negedge clk)
    bus.I_chip_din <= (!bus.O_chip_ce_n && !bus.O_chip_oe_n) ? sram_rd(bus.O_chip_addr) : 16'h0000;
  always @(negedge clk)
    bus2.I_chip_din <= (!bus2.O_chip_oe_n) ? 16'hC0DE : 16'h0000;

  // SRAM commits on the rising edge of WE
  always @(posedge bus.O_chip_we_n) begin
    if (rst_n === 1'b1 && bus.O_chip_ce_n === 1'b0) begin
      wtmp = sram_rd(bus.O_chip_addr);
      for (int b = 0; b < 2; b++)
        if (!bus.O_chip_be_n[b]) wtmp[8*b +: 8] = bus.O_chip_dout[8*b +: 8];
      mem[bus.O_chip_addr] = wtmp;
    end
  end

  typedef struct {
    logic        w;
    logic [15:0] d;
    int          ack_cyc;
  } exp_t;
  exp_t sb[$];

  int          n_oe = 0, n_we = 0, n_doe = 0, n_busy = 0, n_acks = 0;
  logic [1:0]  be_at_we = 2'b11;
  logic [1:0]  be_at_oe = 2'b11;
  logic [15:0] last_rd = 16'h0000;
  exp_t        e;

  // Output monitor: pin activity counters and scoreboard pops on ack
  always @(negedge clk) begin
    if (rst_n) begin
      if (!bus.O_chip_oe_n) begin n_oe++; be_at_oe = bus.O_chip_be_n; end
      if (!bus.O_chip_we_n) begin n_we++; be_at_we = bus.O_chip_be_n; end
      if (bus.O_chip_doe) n_doe++;
      if (bus.O_busy) n_busy++;
      check("doe_oe_overlap", bus.O_chip_doe && !bus.O_chip_oe_n, 1'b0);
      check("doe_oe_overlap2", bus2.O_chip_doe && !bus2.O_chip_oe_n, 1'b0);
      if (bus.O_ack) begin
        n_acks++;
        if (sb.size() == 0) begin
          check("ack_unexpected", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check("ack_cycle", 64'(cyc), 64'(e.ack_cyc));
          if (!e.w) begin
            check("rd_data", bus.O_data, e.d);
            last_rd = e.d;
          end else begin
            check("wr_keeps_odata", bus.O_data, last_rd);
          end
        end
      end
    end
  end

  int b_oe, b_we, b_doe, b_busy;

  // Drive at a negedge where the controller is idle; record expectation.
  task automatic push_exp(input logic w, input logic [1:0] sel,
                          input logic [17:0] a, input logic [15:0] d);
    exp_t x;
    logic [15:0] r;
    x.w = w;
    x.ack_cyc = cyc + 1 + (w ? int'(WW) + 3 : int'(RW) + 1);
    if (w) begin
      r = ref_rd(a);
      for (int b = 0; b < 2; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
      ref_mem[a] = r;
      x.d = 16'h0000;
    end else begin
      x.d = ref_rd(a);
    end
    sb.push_back(x);
  endtask

  task automatic do_req(input logic w, input logic [1:0] sel,
                        input logic [17:0] a, input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    while (bus.O_busy && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("accept_timeout", 1'b1, 1'b0);
    bus.I_stb = 1'b1; bus.I_write = w; bus.I_sel = sel; bus.I_addr = a; bus.I_data = d;
    push_exp(w, sel, a, d);
    @(posedge clk); #1;
    bus.I_stb = 1'b0;
    b_oe = n_oe; b_we = n_we; b_doe = n_doe; b_busy = n_busy;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((bus.O_busy || sb.size() != 0) && n < 100);
    if (n >= 100) check("idle_timeout", 1'b1, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int acks0, n, t_ack, t_acc;

  initial begin
    mem[18'h000A5] = 16'hBEEF;   ref_mem[18'h000A5] = 16'hBEEF;
    mem[18'h3FFFF] = 16'hABCD;   ref_mem[18'h3FFFF] = 16'hABCD;
    for (int i = 0; i < 4; i++) begin
      mem[18'h10 + 18'(i)]     = 16'h1100 + 16'(i * 17);
      ref_mem[18'h10 + 18'(i)] = 16'h1100 + 16'(i * 17);
    end

    rst_n = 1'b0;
    bus.I_stb = 1'b1; bus.I_write = 1'b0; bus.I_sel = 2'b11; bus.I_addr = '0; bus.I_data = '0;
    bus2.I_stb = 1'b0; bus2.I_write = 1'b0; bus2.I_sel = 2'b11; bus2.I_addr = '0; bus2.I_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ce_n", bus.O_chip_ce_n, 1'b1);
    check("rst_oe_n", bus.O_chip_oe_n, 1'b1);
    check("rst_we_n", bus.O_chip_we_n, 1'b1);
    check("rst_be_n", bus.O_chip_be_n, 2'b11);
    check("rst_doe",  bus.O_chip_doe, 1'b0);
    check("rst_ack",  bus.O_ack, 1'b0);
    check("rst_busy", bus.O_busy, 1'b0);
    check("rst_data", bus.O_data, 16'h0000);
    check("rst_addr", bus.O_chip_addr, 18'h0);
    bus.I_stb = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Single read
    do_req(1'b0, 2'b11, 18'h000A5, 16'h0000);
    wait_idle();
    check("rd_oe_cycles", 64'(n_oe - b_oe), 64'(2));
    check("rd_busy_cycles", 64'(n_busy - b_busy), 64'(2));
    check("rd_odata", bus.O_data, 16'hBEEF);

    // Partial write at max address
    do_req(1'b1, 2'b10, 18'h3FFFF, 16'h1234);
    wait_idle();
    check("wr_we_cycles", 64'(n_we - b_we), 64'(2));
    check("wr_doe_cycles", 64'(n_doe - b_doe), 64'(4));
    check("wr_busy_cycles", 64'(n_busy - b_busy), 64'(5));
    check("wr_be_n", be_at_we, 2'b01);
    check("wr_sram_word", sram_rd(18'h3FFFF), 16'h12CD);
    check("wr_odata_kept", bus.O_data, 16'hBEEF);

    // Read back the written word through the chip
    do_req(1'b0, 2'b11, 18'h3FFFF, 16'h0000);
    wait_idle();

    // Read with no byte lanes selected
    do_req(1'b0, 2'b00, 18'h00020, 16'h0000);
    wait_idle();
    check("sel0_be_n", be_at_oe, 2'b11);

    // Back-to-back reads, strobe held high throughout
    acks0 = n_acks;
    @(negedge clk);
    for (int i = 0; i < 4; ) begin
      if (!bus.O_busy) begin
        bus.I_stb = 1'b1; bus.I_write = 1'b0; bus.I_sel = 2'b11;
        bus.I_addr = 18'h10 + 18'(i);
        push_exp(1'b0, 2'b11, 18'h10 + 18'(i), 16'h0000);
        i++;
        if (i == 4) begin @(posedge clk); #1; bus.I_stb = 1'b0; end
      end
      if (i < 4) @(negedge clk);
    end
    wait_idle();
    check("b2b_ack_count", 64'(n_acks - acks0), 64'(4));

    // Reset in the middle of the write pulse
    do_req(1'b1, 2'b11, 18'h00030, 16'hFFFF);
    n = 0;
    do begin @(negedge clk); n++; end while (bus.O_chip_we_n && n < 20);
    check("abort_we_seen", bus.O_chip_we_n, 1'b0);
    acks0 = n_acks;
    #2 rst_n = 1'b0;
    #1;
    check("abort_we_n", bus.O_chip_we_n, 1'b1);
    check("abort_ce_n", bus.O_chip_ce_n, 1'b1);
    check("abort_doe",  bus.O_chip_doe, 1'b0);
    check("abort_busy", bus.O_busy, 1'b0);
    sb.delete();
    ref_mem[18'h00030] = dflt(18'h00030);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_ack", 64'(n_acks - acks0), 64'(0));
    check("abort_no_write", sram_rd(18'h00030), dflt(18'h00030));
    do_req(1'b0, 2'b11, 18'h00011, 16'h0000);
    wait_idle();
    check("post_abort_ack", 64'(n_acks - acks0), 64'(1));

    // TURNAROUND=2: write then read requested immediately
    @(negedge clk);
    bus2.I_stb = 1'b1; bus2.I_write = 1'b1; bus2.I_addr = 18'h5; bus2.I_data = 16'h7777;
    @(posedge clk); #1;
    bus2.I_write = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus2.O_ack && n < 50);
    check("t2_wr_ack", bus2.O_ack, 1'b1);
    t_ack = cyc;
    n = 0;
    while (bus2.O_busy && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (!bus2.O_busy && n < 50) begin @(negedge clk); n++; end
    t_acc = cyc;
    bus2.I_stb = 1'b0;
    check("t2_rd_accept_gap", 64'(t_acc - t_ack), 64'(3));
    n = 0;
    do begin @(negedge clk); n++; end while (!bus2.O_ack && n < 50);
    check("t2_rd_ack_cycle", 64'(cyc - t_acc), 64'(2));
    check("t2_rd_data", bus2.O_data, 16'hC0DE);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
